bfloat_div: RTL and testbench

- Iterative, multi-cycle divider for the team's 16-bit {exponent[7:0], fraction[7:0]} word, the inverse operation of the combinational multiplier `mul`.
- A fraction is normalised when bit 7 is 1; its value is frac/256, in [0.5, 1).
- Computes quotient = a / b using restoring division, one quotient bit per cycle.
- Valid/ready handshakes on both sides; sits beside `mul` in the arithmetic datapath.

---
 rtl/bfloat_pkg.sv | 25 ++
 rtl/frac_div_step.sv | 29 ++
 rtl/bfloat_div.sv | 140 ++++++++++++++
 tb/tb_bfloat_div.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bfloat_pkg.sv
// Shared definitions for the 16-bit {exponent, fraction} arithmetic datapath.
// Contents: field widths, exponent bias, the divider state enum and the
// bf16_t word layout.
package bfloat_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 8;

  // Exponent bias, shared with mul.
  localparam logic [EXP_W-1:0] BIAS = 8'h7F;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    POST,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } bf16_t;

endpackage

// File: rtl/frac_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      : current partial remainder (FRAC_W+2 bits)
//   divisor  : normalised divisor fraction
//   rem_next : remainder after conditional subtract, shifted left by one
//   q_bit    : quotient bit produced by this step
module frac_div_step #(
  parameter int unsigned FRAC_W = 8
) (
  input  logic [FRAC_W+1:0] rem,
  input  logic [FRAC_W-1:0] divisor,
  output logic [FRAC_W+1:0] rem_next,
  output logic              q_bit
);

  logic [FRAC_W+1:0] div_ext;
  logic [FRAC_W+1:0] diff;
  logic [FRAC_W+1:0] kept;

  always_comb begin
    div_ext  = {2'b00, divisor};
    diff     = rem - div_ext;
    q_bit    = (rem >= div_ext);
    kept     = q_bit ? diff : rem;
    // Compare-then-shift form: remainder stays below 2*divisor, so it fits.
    rem_next = kept << 1;
  end

endmodule

// File: rtl/bfloat_div.sv
// Iterative restoring divider for the {exponent, fraction} word: quot = a / b.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (flp_a dividend, flp_b divisor)
//   out_valid/out_ready : result handshake (quot, div_zero)
//   busy                : operation in progress (state != IDLE)
module bfloat_div
  import bfloat_pkg::*;
#(
  parameter int unsigned EXP_W  = bfloat_pkg::EXP_W,
  parameter int unsigned FRAC_W = bfloat_pkg::FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W-1:0] flp_a,
  input  logic [EXP_W+FRAC_W-1:0] flp_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W-1:0] quot,
  output logic                    div_zero,
  output logic                    busy
);

  div_state_t        state;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic [FRAC_W+1:0] rem;
  logic [FRAC_W:0]   q_raw;
  logic [3:0]        cnt;

  logic [FRAC_W+1:0] rem_next;
  logic              q_bit;
  logic [EXP_W-1:0]  e_diff;

  frac_div_step #(.FRAC_W(FRAC_W)) u_step (
    .rem      (rem),
    .divisor  (fb),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign e_diff = ea - eb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ea        <= '0;
      eb        <= '0;
      fa        <= '0;
      fb        <= '0;
      rem       <= '0;
      q_raw     <= '0;
      cnt       <= '0;
      quot      <= '0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ea       <= flp_a[EXP_W+FRAC_W-1:FRAC_W];
            fa       <= flp_a[FRAC_W-1:0];
            eb       <= flp_b[EXP_W+FRAC_W-1:FRAC_W];
            fb       <= flp_b[FRAC_W-1:0];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            // Divisor-zero check wins when both fractions are zero.
            if (flp_b[FRAC_W-1:0] == '0) begin
              quot      <= '0;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (flp_a[FRAC_W-1:0] == '0) begin
              quot      <= '0;
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (fa[FRAC_W-1] && fb[FRAC_W-1]) begin
            rem   <= {2'b00, fa};
            q_raw <= '0;
            cnt   <= '0;
            state <= DIV;
          end else begin
            if (!fa[FRAC_W-1]) begin
              fa <= fa << 1;
              ea <= ea - 1'b1;
            end
            if (!fb[FRAC_W-1]) begin
              fb <= fb << 1;
              eb <= eb - 1'b1;
            end
          end
        end

        DIV: begin
          rem   <= rem_next;
          q_raw <= {q_raw[FRAC_W-1:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == 4'd8) state <= POST;
        end

        POST: begin
          if (q_raw[FRAC_W]) quot <= {e_diff + 1'b1, q_raw[FRAC_W:1]};
          else               quot <= {e_diff, q_raw[FRAC_W-1:0]};
          div_zero  <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bfloat_div.sv
module tb_bfloat_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] flp_a;
  logic [15:0] flp_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic        div_zero;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  bfloat_div #(.EXP_W(8), .FRAC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flp_a     (flp_a),
    .flp_b     (flp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer operands, accept, then count edges after the accepting edge until out_valid.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int n;
    @(negedge clk);
    flp_a    = a;
    flp_b    = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_q, input logic exp_dz, input int exp_lat);
    int n;
    start_op(a, b);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_quot"}, {16'd0, quot}, {16'd0, exp_q});
    check_eq({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flp_a     = '0;
    flp_b     = '0;
    #12;
    check_eq("rst_quot", {16'd0, quot}, 32'd0);
    check_eq("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_iready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("v1", 16'h05C0, 16'h0280, 16'h04C0, 1'b0, 11);
    check_eq("v1_busy", {31'd0, busy}, 32'd1);
    drain("v1");

    run_op("v2", 16'h0380, 16'h01C0, 16'h02AA, 1'b0, 11);
    drain("v2");

    run_op("v3", 16'h0420, 16'h0080, 16'h0380, 1'b0, 13);
    drain("v3");

    out_ready = 1'b0;
    run_op("wrap", 16'h0080, 16'h01FF, 16'hFF80, 1'b0, 11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_quot", {16'd0, quot}, 32'h0000FF80);
      check_eq("hold_iready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain("wrap");

    run_op("dz", 16'h0380, 16'h0500, 16'h0000, 1'b1, 0);
    drain("dz");
    run_op("az", 16'h0700, 16'h0180, 16'h0000, 1'b0, 0);
    drain("az");

    // Reset pulse while the divider is iterating.
    start_op(16'h05C0, 16'h0280);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_quot", {16'd0, quot}, 32'd0);
    check_eq("mid_rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_iready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 16'h05C0, 16'h0280, 16'h04C0, 1'b0, 11);
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
